demux_rr_scheduler: RTL and testbench
=====================================

DEMUX_RR_SCHEDULER -- requirements
Module: demux_rr_scheduler

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, data width of input and each output channel.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in  input  WIDTH  source data beat.
REQ-005 SHALL have port: in_valid  input  1  source beat present.
REQ-006 SHALL have port: in_ready  output  1  scheduler can accept a beat.
REQ-007 SHALL have port: sel  output  2  registered index of the channel currently targeted.
REQ-008 SHALL have ports: y0, y1, y2, y3  output  WIDTH each  channel data outputs.
REQ-009 SHALL have port: out_valid  output  4  one-hot channel valid; bit i qualifies yi.
REQ-010 SHALL have port: out_ready  input  4  per-channel sink ready; bit i for yi.
REQ-011 SHALL have port: beat_cnt  output  16  total beats delivered, wrapping counter.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (in_ready=1, no out_valid) and HOLD (in_ready=0, one out_valid bit high).
REQ-013 IDLE: on in_valid=1 SHALL capture in into hold register, load sel with chosen target, go to HOLD next cycle.
REQ-014 IDLE with in_valid=0 SHALL remain IDLE, no state change.
REQ-015 HOLD: out_valid SHALL equal one-hot(sel); y[sel] SHALL equal hold register; all non-selected y outputs SHALL be 0.
REQ-016 HOLD: when out_ready[sel]=1, beat SHALL complete that cycle; next cycle IDLE, rr pointer = sel+1 mod 4, beat_cnt += 1.
REQ-017 HOLD with out_ready[sel]=0 SHALL hold data, sel and out_valid stable indefinitely; other out_ready bits ignored.
REQ-018 Minimum latency: accept at edge N, out_valid at N+1; one beat per 2 cycles maximum throughput.
REQ-019 Pointer wrap: after delivery to channel 3 next target base SHALL be channel 0.
REQ-020 beat_cnt SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-021 in_ready SHALL be a function of state only (no combinational path from in_valid or out_ready).
REQ-022 Outputs y0..y3, out_valid, sel SHALL be driven from registers (no combinational path from inputs).

Reset
REQ-023 rst_n=0 SHALL immediately force: state IDLE, rr pointer 0, sel 0, hold register 0, out_valid 0, y0..y3 0, beat_cnt 0.
REQ-024 in_ready SHALL be 0 while rst_n=0 and 1 from the first edge after deassertion.
REQ-025 Reset asserted in HOLD SHALL discard the held beat; it SHALL not be delivered or counted.

Configuration
REQ-026 Macro DEMUX_SKIP_BUSY_EN SHALL select target policy at acceptance.
REQ-027 Defined: target = first channel at or after rr pointer (mod 4) whose out_ready is 1 in the accept cycle; if none, target = rr pointer.
REQ-028 Undefined: target = rr pointer always (strict round-robin, waits on busy channel).
REQ-029 Pointer update rule (REQ-016) SHALL be identical in both builds.

Verification
REQ-030 Reset then in_valid=1 with in=0x11,0x22,0x33,0x44,0x55, out_ready=4'b1111 -> delivered on y0,y1,y2,y3,y0; sel 0,1,2,3,0; beat_cnt=5.
REQ-031 Accept 0xA5 to channel 0, out_ready=0 for 10 cycles then 1 -> y0=0xA5, out_valid=4'b0001 stable all 11 cycles, in_ready=0, beat_cnt=1 only after release.
REQ-032 Pointer=1, out_ready=4'b1001 at accept: with DEMUX_SKIP_BUSY_EN -> sel=3, y3 gets beat, next pointer 0; without -> sel=1, waits for out_ready[1].
REQ-033 rst_n pulled low mid-HOLD with 0x7E pending -> all outputs 0 asynchronously, beat_cnt unchanged at 0 after reset, 0x7E never appears.
REQ-034 Preload 65535 deliveries (or force beat_cnt=0xFFFF) then one delivery -> beat_cnt=0x0000.
REQ-035 Every cycle check: out_valid one-hot or zero, non-selected y outputs 0, in_ready=1 iff state IDLE and rst_n=1.

Source files
------------

// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler: takes one beat at a time from a single source and
// delivers it to one of four sink channels in round-robin order.
//
// Handshake: a beat moves when valid and ready are both 1 on the same rising
// edge. The source side uses in_valid/in_ready. Each sink channel i uses
// out_valid[i]/out_ready[i]. Once valid is raised, it and its data stay
// stable until the transfer happens.
//
// Build option: define DEMUX_SKIP_BUSY_EN to let acceptance skip channels
// that are busy, choosing the first ready channel at or after the pointer.
// Left undefined, the build uses strict round-robin.
// dbg_state exposes the FSM state (0 = IDLE, 1 = HOLD).
module demux_rr_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [15:0]      beat_cnt,
  output logic             dbg_state
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       rr_q, rr_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [15:0]      beat_cnt_q, beat_cnt_d;
  // Goes high on the first edge after reset is released, so in_ready stays
  // low while reset is held and comes from a register afterwards.
  logic             run_q;
  logic [1:0]       target;

`ifdef DEMUX_SKIP_BUSY_EN
  logic       found;
  logic [1:0] cand;

  // Choose the first ready channel at or after the pointer, or fall back to the pointer.
  always_comb begin
    target = rr_q;
    found  = 1'b0;
    cand   = rr_q;
    for (int k = 0; k < 4; k++) begin
      cand = rr_q + 2'(k);
      if (!found && out_ready[cand]) begin
        target = cand;
        found  = 1'b1;
      end
    end
  end
`else
  // Strict round-robin: the target is always the pointer.
  always_comb begin
    target = rr_q;
  end
`endif

  // Next-state logic: accept in IDLE, deliver in HOLD.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    sel_d      = sel_q;
    hold_d     = hold_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid && run_q) begin
          hold_d  = in;
          sel_d   = target;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready[sel_q]) begin
          state_d    = IDLE;
          rr_d       = sel_q + 2'd1;
          beat_cnt_d = beat_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; an async reset discards any beat being held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= 2'd0;
      sel_q      <= 2'd0;
      hold_q     <= '0;
      beat_cnt_q <= 16'd0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      sel_q      <= sel_d;
      hold_q     <= hold_d;
      beat_cnt_q <= beat_cnt_d;
      run_q      <= 1'b1;
    end
  end

  // The outputs decode register state only; there is no path from any input.
  assign in_ready  = run_q && (state_q == IDLE);
  assign sel       = sel_q;
  assign out_valid = (state_q == HOLD) ? (4'b0001 << sel_q) : 4'b0000;
  assign y0        = (state_q == HOLD && sel_q == 2'd0) ? hold_q : '0;
  assign y1        = (state_q == HOLD && sel_q == 2'd1) ? hold_q : '0;
  assign y2        = (state_q == HOLD && sel_q == 2'd2) ? hold_q : '0;
  assign y3        = (state_q == HOLD && sel_q == 2'd3) ? hold_q : '0;
  assign beat_cnt  = beat_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Testbench for demux_rr_scheduler: directed vectors, a reference model at
// the transaction level, and an output compare on every falling edge.
module tb_demux_rr_scheduler;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  sel;
  logic [7:0]  y0, y1, y2, y3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready = 4'h0;
  logic [15:0] beat_cnt;
  logic        dbg_state;

  always #5 clk = ~clk;

  demux_rr_scheduler #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .y0(y0), .y1(y1), .y2(y2), .y3(y3), .out_valid(out_valid),
    .out_ready(out_ready), .beat_cnt(beat_cnt), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en  = 1'b0;
  logic preload = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks the beat in flight (if any) and the round-robin
  // pointer. alive becomes 1 on the first edge after reset is released.
  logic        m_alive = 1'b0;
  logic        m_pend  = 1'b0;
  logic [7:0]  m_data  = 8'h00;
  int          m_tgt   = 0;
  int          m_ptr   = 0;
  int          m_sel   = 0;
  logic [15:0] m_cnt   = 16'h0;

  function automatic int pick(input int ptr, input logic [3:0] rdy);
`ifdef DEMUX_SKIP_BUSY_EN
    for (int k = 0; k < 4; k++)
      if (rdy[(ptr + k) % 4]) return (ptr + k) % 4;
`endif
    return ptr;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_alive = 1'b0; m_pend = 1'b0; m_data = 8'h00;
      m_tgt = 0; m_ptr = 0; m_sel = 0; m_cnt = 16'h0;
    end else begin
      if (preload) m_cnt = 16'hFFFF;
      if (!m_alive) m_alive = 1'b1;
      else if (!m_pend) begin
        if (in_valid) begin
          m_tgt  = pick(m_ptr, out_ready);
          m_sel  = m_tgt;
          m_data = din;
          m_pend = 1'b1;
        end
      end else if (out_ready[m_tgt]) begin
        m_pend = 1'b0;
        m_ptr  = (m_tgt + 1) % 4;
        m_cnt  = 16'((int'(m_cnt) + 1) % 65536);
      end
    end
  end

  function automatic logic [7:0] exp_y(input int i);
    return (m_pend && m_tgt == i) ? m_data : 8'h00;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  32'(in_ready),  32'(m_alive && !m_pend));
      check("out_valid", 32'(out_valid), m_pend ? (32'd1 << m_tgt) : 32'd0);
      check("onehot",    32'($countones(out_valid) <= 1), 32'd1);
      check("sel",       32'(sel),       32'(m_sel));
      check("y0",        32'(y0),        32'(exp_y(0)));
      check("y1",        32'(y1),        32'(exp_y(1)));
      check("y2",        32'(y2),        32'(exp_y(2)));
      check("y3",        32'(y3),        32'(exp_y(3)));
      check("beat_cnt",  32'(beat_cnt),  32'(m_cnt));
      check("state",     32'(dbg_state), 32'(m_pend));
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one beat while IDLE; return #1 after the falling edge of the HOLD cycle.
  task automatic accept(input logic [7:0] d, input logic [3:0] rdy);
    @(negedge clk); #1;
    din = d; in_valid = 1'b1; out_ready = rdy;
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] seq [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [7:0] rnd_d [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
  logic [3:0] rnd_r [4] = '{4'b0100, 4'b0000, 4'b0010, 4'b1000};
  int         rnd_h [4] = '{2, 1, 0, 3};

  initial begin
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // Five beats with all sinks ready: channels 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      accept(seq[i], 4'hF);
      check("seq_sel", 32'(sel), 32'(i % 4));
      check("seq_valid", 32'(out_valid), 32'd1 << (i % 4));
      case (i % 4)
        0: check("seq_y", 32'(y0), 32'(seq[i]));
        1: check("seq_y", 32'(y1), 32'(seq[i]));
        2: check("seq_y", 32'(y2), 32'(seq[i]));
        default: check("seq_y", 32'(y3), 32'(seq[i]));
      endcase
    end
    idle_cycle();
    check("seq_cnt", 32'(beat_cnt), 32'd5);

    // Move the pointer back to 0, then stall channel 0 for 10 cycles.
    for (int i = 0; i < 3; i++) accept(8'h60 + 8'(i), 4'hF);
    idle_cycle();
    accept(8'hA5, 4'h0);
    out_ready = 4'b1110;
    for (int i = 0; i < 11; i++) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_y0", 32'(y0), 32'hA5);
      check("stall_rdy", 32'(in_ready), 32'd0);
      check("stall_cnt", 32'(beat_cnt), 32'd8);
      if (i < 10) idle_cycle();
    end
    out_ready = 4'b0001;
    idle_cycle();
    check("release_cnt", 32'(beat_cnt), 32'd9);
    check("release_valid", 32'(out_valid), 32'd0);

    // Pointer is now 1; only sinks 0 and 3 are ready at acceptance.
    accept(8'h3C, 4'b1001);
`ifdef DEMUX_SKIP_BUSY_EN
    check("skip_sel", 32'(sel), 32'd3);
    check("skip_y3", 32'(y3), 32'h3C);
    idle_cycle();
`else
    check("strict_sel", 32'(sel), 32'd1);
    check("strict_y1", 32'(y1), 32'h3C);
    idle_cycle();
    idle_cycle();
    check("strict_wait", 32'(out_valid), 32'b0010);
    out_ready = 4'b0010;
    idle_cycle();
`endif
    check("p32_cnt", 32'(beat_cnt), 32'd10);

    // Reset while 0x7E is held; the beat must be dropped.
    accept(8'h7E, 4'h0);
`ifdef DEMUX_SKIP_BUSY_EN
    check("ptr_after_skip", 32'(sel), 32'd0);
`else
    check("ptr_after_strict", 32'(sel), 32'd2);
`endif
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_y", 32'(y0 | y1 | y2 | y3), 32'd0);
    check("arst_rdy", 32'(in_ready), 32'd0);
    check("arst_cnt", 32'(beat_cnt), 32'd0);
    check("arst_sel", 32'(sel), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    din = 8'h99; in_valid = 1'b1; out_ready = 4'h0;
    #1 check("post_rst_rdy0", 32'(in_ready), 32'd0);
    @(negedge clk); #1;
    check("post_rst_rdy1", 32'(in_ready), 32'd1);
    check("post_rst_noacc", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    in_valid = 1'b0;
    check("first_acc_valid", 32'(out_valid), 32'd1);
    check("first_acc_y0", 32'(y0), 32'h99);
    out_ready = 4'hF;
    idle_cycle();
    check("first_acc_cnt", 32'(beat_cnt), 32'd1);

    // Preload the counter to 0xFFFF, then one delivery wraps it to 0.
    force dut.beat_cnt_d = 16'hFFFF;
    preload = 1'b1;
    @(posedge clk); #1;
    release dut.beat_cnt_d;
    preload = 1'b0;
    idle_cycle();
    check("preload_cnt", 32'(beat_cnt), 32'hFFFF);
    accept(8'h5A, 4'hF);
    idle_cycle();
    check("wrap_cnt", 32'(beat_cnt), 32'd0);

    // Mixed sink-ready patterns, checked against the model only.
    for (int i = 0; i < 4; i++) begin
      accept(rnd_d[i], rnd_r[i]);
      if (rnd_h[i] > 0) begin
        out_ready = 4'h0;
        repeat (rnd_h[i]) idle_cycle();
      end
      out_ready = 4'hF;
      idle_cycle();
    end
    repeat (3) idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
